// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans a 4x3 membrane keypad, debounces whole scan
// frames and emits a one-cycle key code on invalue for each fresh press.
// invalue rests at 13 ("no command") at all other times.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,  // cycles each column is driven before sampling (>=2)
    parameter int DEBOUNCE = 4      // identical frames needed to accept a change (1..255)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] invalue
);

    localparam int               DIV_W        = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DEB_MAX      = 8'(DEBOUNCE);
    localparam logic [3:0]       CODE_NONE    = 4'd13;
    localparam logic [3:0]       CODE_INVALID = 4'd15;

    // Key code for the switch at (row r, column c).
    function automatic logic [3:0] key_code(input int r, input int c);
        logic [3:0] code;
        if (r == 3) begin
            code = (c == 0) ? 4'd11 : ((c == 1) ? 4'd0 : 4'd10);
        end else begin
            code = 4'(r * 3 + c + 1);
        end
        return code;
    endfunction

    logic [1:0]       col_idx;
    logic [DIV_W-1:0] div;
    // Columns 0 and 1 of the current frame; column 2 is decoded straight
    // from the pins on the frame-end cycle, so it never needs storing.
    logic [7:0]       snap;
    logic [7:0]       stable;
    logic [3:0]       cand;
    logic [3:0]       accepted;

    logic [11:0]      frame_bits;
    logic [3:0]       n_set;
    logic [3:0]       d_code;
    logic [3:0]       nxt_cand;
    logic [7:0]       nxt_stable;
    logic             accept_now;

    // Decode the completed frame and work out the debounce update it implies.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        frame_bits = {~row, snap};
        n_set      = 4'd0;
        d_code     = CODE_NONE;
        nxt_cand   = cand;
        nxt_stable = stable;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (frame_bits[c*4 + r]) begin
                    n_set  = n_set + 4'd1;
                    d_code = key_code(r, c);
                end
            end
        end
        if (n_set > 4'd1) begin
            d_code = CODE_INVALID;
        end

        if (d_code == CODE_INVALID) begin
            nxt_cand   = CODE_INVALID;
            nxt_stable = 8'd0;
        end else if (d_code == cand) begin
            nxt_stable = (stable == DEB_MAX) ? stable : stable + 8'd1;
        end else begin
            nxt_cand   = d_code;
            nxt_stable = 8'd1;
        end
        accept_now = (nxt_stable == DEB_MAX) && (nxt_cand != accepted);
    end

    // Column scan, per-column sampling, frame-end debounce and press events.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            col_idx  <= 2'd0;
            div      <= '0;
            snap     <= '0;
            col      <= 3'b110;
            stable   <= 8'd0;
            cand     <= CODE_NONE;
            accepted <= CODE_NONE;
            invalue  <= CODE_NONE;
        end else begin
            invalue <= CODE_NONE;
            if (div == DIV_LAST) begin
                div <= '0;
                case (col_idx)
                    2'd0: begin
                        snap[3:0] <= ~row;
                        col_idx   <= 2'd1;
                        col       <= 3'b101;
                    end
                    2'd1: begin
                        snap[7:4] <= ~row;
                        col_idx   <= 2'd2;
                        col       <= 3'b011;
                    end
                    default: begin
                        col_idx <= 2'd0;
                        col     <= 3'b110;
                        stable  <= nxt_stable;
                        cand    <= nxt_cand;
                        if (accept_now) begin
                            accepted <= nxt_cand;
                            // Only a press out of the released state is reported.
                            if (accepted == CODE_NONE) begin
                                invalue <= nxt_cand;
                            end
                        end
                    end
                endcase
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x3 membrane keypad and emits key codes in the safe controller's input encoding on `invalue`.
- Output is 4'd13 ("no command") at all times except exactly one cycle per debounced key press.
- Sits between the keypad pins and the safe controller; the safe controller acts on every cycle where `invalue` != 13.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven low before its rows are sampled (>=2).
- DEBOUNCE, 4, consecutive identical scan frames required to accept a press or a release (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- row  input  4  keypad row lines, active-low, externally pulled up; row[0] = top row
- col  output 3  keypad column drives, active-low one-hot; col[0] = left column
- invalue  output 4  key code: 0-9 digits, 10 = #, 11 = *, 13 = no command

Behaviour:
- Reset (rst high at a clk edge), all values take effect next cycle:
  - col = 3'b110; invalue = 4'd13.
  - Column index = 0, divider = 0, frame snapshot cleared.
  - Stable counter = 0, candidate = none, accepted = none.
  - rst has priority over all other activity; reset mid-frame discards the partial frame.
- Keymap (row, col) -> code:
  - (0,0)=1, (0,1)=2, (0,2)=3
  - (1,0)=4, (1,1)=5, (1,2)=6
  - (2,0)=7, (2,1)=8, (2,2)=9
  - (3,0)=11, (3,1)=0, (3,2)=10
- Scan sequencing:
  - Divider counts 0..SCAN_DIV-1 while column c is driven (col = ~(1<<c)).
  - On divider == SCAN_DIV-1: latch ~row into snapshot bits for column c, then advance c (0->1->2->0).
  - col changes on the cycle after the sample.
  - One frame = 3*SCAN_DIV cycles, ending at the column-2 sample.
- Frame decode (at frame end):
  - No bits set -> NONE.
  - Exactly one bit set -> that key's code.
  - Two or more bits set -> INVALID.
- Debounce (evaluated at frame end, using the decoded value d):
  - If d == INVALID: stable counter = 0, candidate = INVALID, accepted unchanged.
  - Else if d == candidate: stable counter increments, saturating at DEBOUNCE.
  - Else: candidate = d, stable counter = 1.
  - When the stable counter reaches DEBOUNCE (after the update above) and candidate != accepted: accepted = candidate.
- Event generation:
  - When accepted changes from NONE to key K, invalue = K for exactly the next cycle, then 13.
  - Transitions key->NONE produce no output.
  - Key A -> key B with no debounced release between them: accepted becomes B, no event.
  - Only NONE -> key emits, so a sliding finger never double-fires.
  - Held key: single event, no autorepeat, regardless of hold time.
- Latency: key closed before frame k starts -> event on cycle (end of frame k+DEBOUNCE-1) + 1.
- Multi-key: INVALID frames never create or clear a press. Holding A then adding B yields no event. Releasing B back to A alone yields no event, since accepted is still A.
- Bounce: any frame whose decode differs from candidate restarts the stable count.
- Counters never wrap past their bounds; the divider and column index wrap only as specified.

Test Plan:
(Bench parameters SCAN_DIV=4, DEBOUNCE=3, frame = 12 cycles, first frame starts at cycle 1 after rst deasserts.)
1. Hold rst 2 cycles -> col = 3'b110, invalue = 13 on the first post-reset cycle; col sequence 110,101,011 each held 4 cycles, then repeating.
2. Assert row[1] low only while col[2] low, from frame 1 onward (key 6) -> invalue = 6 for exactly one cycle, the cycle after frame 3 ends (cycle 37); 13 at all other cycles; holding 20 frames gives no repeat.
3. Key 5 pressed for 3 frames, released 3 frames, pressed 3 frames -> two single-cycle pulses of 5. Release for only 2 frames between presses -> one pulse only.
4. Bounce: key # present in frames 1,2, absent in 3, present in 4,5,6 -> exactly one pulse of 10, after frame 6 ends.
5. Keys 1 and 9 both held for 5 frames -> no pulse. Then 9 released, 1 held for 3 frames -> one pulse of 1.
6. Key 0 held; rst asserted mid-frame 2 -> invalue stays 13 through reset. Key still held afterwards -> pulse of 0 after frame 3 of the new scan sequence.
